xgcd_apb_master: RTL

//  APB3 requester (initiator) that drives the XGCD core register slave.
//  - Takes single register read/write commands on a valid/ready port and runs the
//    APB setup and access phases.
//  - Returns read data plus a completion status on a valid/ready response port.
//  - Sits between the test/host sequencer and the XGCD APB slave. One transfer in flight.

---
 rtl/xgcd_apb_pkg.sv | 25 ++
 rtl/xgcd_apb_timer.sv | 28 ++
 rtl/xgcd_apb_master.sv | 107 ++++++++++
 3 files changed

// File: rtl/xgcd_apb_pkg.sv
// Shared types and constants for the XGCD APB requester.
package xgcd_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_SLV     = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_ALIGN   = 2'b11
    } rsp_err_t;

    localparam logic [31:0] XGCD_ID_VALUE = 32'h5A5A5A5A;

    // Counter width able to hold 0..n; never narrower than one bit.
    function automatic int cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/xgcd_apb_timer.sv
// Wait-state watchdog: loads the limit on clear and counts down on each enabled cycle.
module xgcd_apb_timer #(
    parameter int WIDTH = 5
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= limit;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    // The last permitted wait cycle is the one where only one count remains; a zero limit never fires.
    assign expired = enable && (cnt == WIDTH'(1));

endmodule

// File: rtl/xgcd_apb_master.sv
// APB3 requester for the XGCD register slave: one command in flight, valid/ready command and response ports.
module xgcd_apb_master
    import xgcd_apb_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic [1:0]            RSP_ERR,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic                  BUSY
);

    localparam int TW = cnt_width(TIMEOUT_CYCLES);

    state_t state, state_nx;
    logic   misaligned;
    logic   timeout_hit;

    assign misaligned = (CMD_ADDR[1:0] != 2'b00);

    xgcd_apb_timer #(
        .WIDTH(TW)
    ) u_timer (
        .CLK    (CLK),
        .RESETn (RESETn),
        .clear  (state == SETUP),
        .enable ((state == ACCESS) && !PREADY),
        .limit  (TW'(TIMEOUT_CYCLES)),
        .expired(timeout_hit)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (CMD_VALID) state_nx = misaligned ? RESP : SETUP;
            SETUP:   state_nx = ACCESS;
            ACCESS:  if (PREADY || timeout_hit) state_nx = RESP;
            RESP:    if (RSP_READY) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control outputs decode straight from the state register so reset removes them at once.
    assign CMD_READY = (state == IDLE);
    assign PSEL      = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);
    assign RSP_VALID = (state == RESP);
    assign BUSY      = (state != IDLE);

    // APB address/data only move when a transfer launches; the response is captured once on entry to RESP.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            RSP_RDATA <= '0;
            RSP_ERR   <= ERR_OK;
        end else begin
            if ((state == IDLE) && CMD_VALID) begin
                if (misaligned) begin
                    RSP_RDATA <= '0;
                    RSP_ERR   <= ERR_ALIGN;
                end else begin
                    PADDR  <= {CMD_ADDR[ADDR_WIDTH-1:2], 2'b00};
                    PWRITE <= CMD_WRITE;
                    PWDATA <= CMD_WDATA;
                end
            end
            if (state == ACCESS) begin
                if (PREADY) begin
                    RSP_RDATA <= (PWRITE || PSLVERR) ? '0 : PRDATA;
                    RSP_ERR   <= PSLVERR ? ERR_SLV : ERR_OK;
                end else if (timeout_hit) begin
                    RSP_RDATA <= '0;
                    RSP_ERR   <= ERR_TIMEOUT;
                end
            end
        end
    end

endmodule
